// File: rtl/ndp_pkg.sv
// Shared AHB encodings, bridge FSM states and scratch-pad address field offsets.
// Also used by host driver tests to build scratch-pad byte addresses.
package ndp_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   localparam logic [2:0] HSIZE_WORD = 3'b010;

   // Byte-address layout: [1:0] offset, [2] word, [5:3] layer, [11:6] num, [12] type
   localparam int SP_ADDR_LSB = 2;
   localparam int LAYER_LSB   = 3;
   localparam int NUM_LSB     = 6;
   localparam int TYPE_BIT    = 12;

   // One state per data-phase cycle
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_WR   = 3'd1;
   localparam logic [2:0] ST_RD1  = 3'd2;
   localparam logic [2:0] ST_RD2  = 3'd3;
   localparam logic [2:0] ST_ERR1 = 3'd4;
   localparam logic [2:0] ST_ERR2 = 3'd5;

   typedef struct packed {
      logic       bram_type;
      logic [5:0] bram_num;
      logic [2:0] bram_layer;
      logic       bram_addr;
   } sp_sel_t;

endpackage

// File: rtl/sp_addr_decode.sv
// Purpose: split a host byte address into scratch-pad port-A fields and flag illegal accesses.
// Latency: combinational.
// Backpressure: none; evaluated every cycle from the address-phase inputs.
module sp_addr_decode
   import ndp_pkg::*;
#(
   parameter int SYS_WIDTH  = 64,
   parameter int SYS_HEIGHT = 1
) (
   input  logic [12:0] addr,
   input  logic [2:0]  size,
   output sp_sel_t     fields,
   output logic        illegal
);

   localparam logic [6:0] WGT_LIMIT = 7'(SYS_WIDTH);
   localparam logic [6:0] ACT_LIMIT = 7'(SYS_HEIGHT);

   logic [6:0] num_limit;

   always_comb begin
      fields.bram_type  = addr[TYPE_BIT];
      fields.bram_num   = addr[NUM_LSB +: 6];
      fields.bram_layer = addr[LAYER_LSB +: 3];
      fields.bram_addr  = addr[SP_ADDR_LSB];
      num_limit = fields.bram_type ? WGT_LIMIT : ACT_LIMIT;
      illegal   = (size != HSIZE_WORD) || (addr[1:0] != 2'b00) ||
                  ({1'b0, fields.bram_num} >= num_limit);
   end

endmodule

// File: rtl/ahb_scratch_pad_bridge.sv
// Purpose: AHB-Lite slave giving the host write/readback access to scratch-pad port A.
// Latency: write 0 wait states, read 1 wait state, error 1 wait state (two-cycle ERROR).
// Backpressure: HREADYOUT low in RD1/ERR1 only; next address phase is held by the master.
module ahb_scratch_pad_bridge
   import ndp_pkg::*;
#(
   parameter int SYS_WIDTH  = 64,
   parameter int SYS_HEIGHT = 1,
   parameter int ERRW       = 8
) (
   input  logic            HCLK,
   input  logic            HRESETn,
   input  logic            HSEL,
   input  logic [31:0]     HADDR,
   input  logic [1:0]      HTRANS,
   input  logic            HWRITE,
   input  logic [2:0]      HSIZE,
   input  logic [31:0]     HWDATA,
   input  logic            HREADY,
   output logic            HREADYOUT,
   output logic            HRESP,
   output logic [31:0]     HRDATA,
   output logic            sp_en,
   output logic            sp_wen,
   output logic            sp_bram_type,
   output logic [2:0]      sp_bram_layer,
   output logic [5:0]      sp_bram_num,
   output logic            sp_bram_addr,
   output logic [31:0]     sp_data_in,
   input  logic [31:0]     sp_rdata,
   output logic [ERRW-1:0] err_count
);

   logic [2:0]      state;
   logic [2:0]      state_nxt;
   logic            trans_active;
   logic            accept;
   logic            data_done;
   logic            dec_illegal;
   sp_sel_t         dec_fields;
   sp_sel_t         sel_q;
   logic [ERRW-1:0] err_q;
   logic            unused_haddr;

   assign unused_haddr = ^HADDR[31:13];

   sp_addr_decode #(
      .SYS_WIDTH  (SYS_WIDTH),
      .SYS_HEIGHT (SYS_HEIGHT)
   ) u_decode (
      .addr    (HADDR[12:0]),
      .size    (HSIZE),
      .fields  (dec_fields),
      .illegal (dec_illegal)
   );

   always_comb begin
      trans_active = 1'b0;
      case (HTRANS)
         HTRANS_IDLE, HTRANS_BUSY:  trans_active = 1'b0;
         HTRANS_NONSEQ, HTRANS_SEQ: trans_active = 1'b1;
         default:                   trans_active = 1'b0;
      endcase
   end

   assign accept    = HSEL && HREADY && trans_active;
   // Only the first cycle of a read or error stalls; every other state completes a data phase
   assign data_done = (state != ST_RD1) && (state != ST_ERR1);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RD1:  state_nxt = ST_RD2;
         ST_ERR1: state_nxt = ST_ERR2;
         default: begin
            if (!accept)
               state_nxt = ST_IDLE;
            else if (dec_illegal)
               state_nxt = ST_ERR1;
            else if (HWRITE)
               state_nxt = ST_WR;
            else
               state_nxt = ST_RD1;
         end
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state <= ST_IDLE;
         sel_q <= '0;
         err_q <= '0;
      end else begin
         state <= state_nxt;
         // Fields stay put through RD2 because sp_rdata is muxed by them
         if (data_done && accept && !dec_illegal)
            sel_q <= dec_fields;
         if ((state == ST_ERR1) && (err_q != {ERRW{1'b1}}))
            err_q <= err_q + 1'b1;
      end
   end

   assign HREADYOUT     = data_done;
   assign HRESP         = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
   assign HRDATA        = (state == ST_RD2) ? sp_rdata : 32'h0;
   assign sp_en         = (state == ST_WR) || (state == ST_RD1);
   assign sp_wen        = (state == ST_WR);
   assign sp_data_in    = (state == ST_WR) ? HWDATA : 32'h0;
   assign sp_bram_type  = sel_q.bram_type;
   assign sp_bram_layer = sel_q.bram_layer;
   assign sp_bram_num   = sel_q.bram_num;
   assign sp_bram_addr  = sel_q.bram_addr;
   assign err_count     = err_q;

endmodule

// File: tb/tb_ahb_scratch_pad_bridge.sv
// Bench for ahb_scratch_pad_bridge: table vectors, hand sequences and random traffic
// checked against a byte-address level model of the scratch pad and error counter.
module tb_ahb_scratch_pad_bridge;
   import ndp_pkg::*;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;
   logic        sp_en;
   logic        sp_wen;
   logic        sp_bram_type;
   logic [2:0]  sp_bram_layer;
   logic [5:0]  sp_bram_num;
   logic        sp_bram_addr;
   logic [31:0] sp_data_in;
   logic [31:0] sp_rdata;
   logic [7:0]  err_count;

   always #5 HCLK = ~HCLK;
   assign HREADY = HREADYOUT;

   ahb_scratch_pad_bridge dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
      .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .sp_en(sp_en), .sp_wen(sp_wen),
      .sp_bram_type(sp_bram_type), .sp_bram_layer(sp_bram_layer), .sp_bram_num(sp_bram_num),
      .sp_bram_addr(sp_bram_addr), .sp_data_in(sp_data_in), .sp_rdata(sp_rdata),
      .err_count(err_count)
   );

   typedef struct {
      logic        sel;
      logic [1:0]  trans;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } xfer_t;

   typedef struct {
      logic [31:0] rdata;
      logic        resp;
      int          waits;
      logic        stall_resp;
   } res_t;

   typedef struct {
      xfer_t       x;
      logic        resp;
      int          waits;
      logic [31:0] rdata;
      int          en;
      int          err;
      logic [10:0] fld;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int en_cycles = 0;
   int dat_leak = 0;
   logic [31:0] bram [int];
   logic [31:0] ref_mem [int];
   int ref_err = 0;
   int ref_en = 0;
   res_t res_q[$];
   res_t exp_q[$];

   function automatic logic [31:0] init_val(input int w);
      return (32'(w) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
   endfunction

   // Scratch-pad port A: one-cycle read latency, write visible to the next read
   always @(posedge HCLK) begin
      int idx;
      idx = int'({sp_bram_type, sp_bram_num, sp_bram_layer, sp_bram_addr});
      if (sp_en) begin
         en_cycles++;
         if (sp_wen)
            bram[idx] = sp_data_in;
         else
            sp_rdata <= bram.exists(idx) ? bram[idx] : init_val(idx);
      end
      if (!sp_wen && sp_data_in !== 32'h0) dat_leak++;
      if (sp_wen && !sp_en) dat_leak++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic xfer_t mk(input logic sel, input logic [1:0] tr, input logic wr,
                                input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
      xfer_t x;
      x.sel = sel; x.trans = tr; x.wr = wr; x.size = sz; x.addr = a; x.wdata = d;
      return x;
   endfunction

   function automatic logic [31:0] ref_rd(input int w);
      return ref_mem.exists(w) ? ref_mem[w] : init_val(w);
   endfunction

   // Model straight from the address map: word = byte address / 4 within the 8 KB window
   function automatic res_t ref_xfer(input xfer_t x);
      res_t r;
      int word, num, typ, limit;
      logic illegal;
      r.rdata = 32'h0; r.resp = 1'b0; r.waits = 0; r.stall_resp = 1'b0;
      if (!(x.sel && x.trans >= 2)) return r;
      word  = int'((x.addr / 4) % 2048);
      num   = int'((x.addr / 64) % 64);
      typ   = int'((x.addr / 4096) % 2);
      limit = (typ == 1) ? 64 : 1;
      illegal = (x.size != 3'd2) || (x.addr % 4 != 0) || (num >= limit);
      if (illegal) begin
         ref_err = (ref_err < 255) ? ref_err + 1 : 255;
         r.resp = 1'b1; r.waits = 1; r.stall_resp = 1'b1;
         return r;
      end
      ref_en++;
      if (x.wr) begin
         ref_mem[word] = x.wdata;
      end else begin
         r.rdata = ref_rd(word);
         r.waits = 1;
      end
      return r;
   endfunction

   task automatic drive_idle();
      HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HSIZE = HSIZE_WORD;
      HADDR = 32'h0; HWDATA = 32'h0;
   endtask

   // Pipelined master; entered and left 1 time unit after a rising edge
   task automatic run_seq(input xfer_t xs[$]);
      xfer_t a;
      int    waits;
      logic  sr;
      res_q.delete();
      for (int i = 0; i <= xs.size(); i++) begin
         if (i < xs.size()) a = xs[i];
         else a = mk(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'h0);
         HSEL = a.sel; HTRANS = a.trans; HWRITE = a.wr; HSIZE = a.size; HADDR = a.addr;
         if (i > 0) HWDATA = xs[i-1].wdata;
         else HWDATA = 32'h0;
         waits = 0; sr = 1'b0;
         @(negedge HCLK);
         while (HREADYOUT !== 1'b1 && waits < 8) begin
            sr = sr | HRESP;
            waits++;
            @(negedge HCLK);
         end
         if (i > 0) res_q.push_back('{HRDATA, HRESP, waits, sr});
         @(posedge HCLK);
         #1;
      end
      drive_idle();
   endtask

   task automatic apply(input xfer_t xs[$]);
      exp_q.delete();
      foreach (xs[k]) exp_q.push_back(ref_xfer(xs[k]));
      run_seq(xs);
   endtask

   function automatic xfer_t rnd_xfer();
      xfer_t x;
      logic [31:0] a;
      int r, typ, num;
      r = $urandom_range(0, 7);
      x.sel   = ($urandom_range(0, 9) != 0);
      x.trans = (r < 1) ? HTRANS_IDLE : (r < 2) ? HTRANS_BUSY : (r < 5) ? HTRANS_NONSEQ : HTRANS_SEQ;
      x.wr    = 1'($urandom_range(0, 1));
      x.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : HSIZE_WORD;
      typ = $urandom_range(0, 1);
      num = (typ == 1) ? $urandom_range(0, 3) : (($urandom_range(0, 7) == 0) ? $urandom_range(1, 63) : 0);
      a = $urandom;
      a[12]   = 1'(typ);
      a[11:6] = 6'(num);
      a[5:3]  = {2'b00, 1'($urandom_range(0, 1))};
      a[1:0]  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      x.addr  = a;
      x.wdata = $urandom;
      return x;
   endfunction

   function automatic logic [10:0] fld_now();
      return {sp_bram_type, sp_bram_num, sp_bram_layer, sp_bram_addr};
   endfunction

   initial begin
      vec_t  vt[14];
      xfer_t q[$];
      int    e0, r0, total;

      // Expected values are written from the address map by hand
      vt[0]  = '{mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h10D4, 32'hDEADBEEF),    0, 0, 32'h0,        1, 0, 11'h435};
      vt[1]  = '{mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10D4, 32'h0),           0, 1, 32'hDEADBEEF, 1, 0, 11'h435};
      vt[2]  = '{mk(1, HTRANS_SEQ,    1, HSIZE_WORD, 32'h0038, 32'h12345678),    0, 0, 32'h0,        1, 0, 11'h00E};
      vt[3]  = '{mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h0038, 32'h0),           0, 1, 32'h12345678, 1, 0, 11'h00E};
      vt[4]  = '{mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h0040, 32'h0),           1, 1, 32'h0,        0, 1, 11'h00E};
      vt[5]  = '{mk(1, HTRANS_NONSEQ, 1, 3'b000,     32'h10D4, 32'h11111111),    1, 1, 32'h0,        0, 2, 11'h00E};
      vt[6]  = '{mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10D6, 32'h0),           1, 1, 32'h0,        0, 3, 11'h00E};
      vt[7]  = '{mk(1, HTRANS_BUSY,   0, HSIZE_WORD, 32'h10D4, 32'h0),           0, 0, 32'h0,        0, 3, 11'h00E};
      vt[8]  = '{mk(0, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h10D4, 32'hFFFFFFFF),    0, 0, 32'h0,        0, 3, 11'h00E};
      vt[9]  = '{mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10D4, 32'h0),           0, 1, 32'hDEADBEEF, 1, 3, 11'h435};
      vt[10] = '{mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h1FC0, 32'hA5A50001),    0, 0, 32'h0,        1, 3, 11'h7F0};
      vt[11] = '{mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h1FC0, 32'h0),           0, 1, 32'hA5A50001, 1, 3, 11'h7F0};
      vt[12] = '{mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'hABCDF0D4, 32'h0),       0, 1, 32'hDEADBEEF, 1, 3, 11'h435};
      vt[13] = '{mk(1, HTRANS_IDLE,   1, HSIZE_WORD, 32'h0038, 32'h77777777),    0, 0, 32'h0,        0, 3, 11'h435};

      HRESETn = 1'b0;
      drive_idle();
      #1;
      chk("reset_hreadyout", 32'(HREADYOUT), 32'h1);
      chk("reset_hresp", 32'(HRESP), 32'h0);
      chk("reset_sp_en", 32'(sp_en), 32'h0);
      chk("reset_sp_wen", 32'(sp_wen), 32'h0);
      chk("reset_fields", 32'(fld_now()), 32'h0);
      chk("reset_err_count", 32'(err_count), 32'h0);
      chk("reset_hrdata", HRDATA, 32'h0);
      repeat (2) @(posedge HCLK);
      @(negedge HCLK);
      HRESETn = 1'b1;
      @(posedge HCLK);
      #1;

      for (int i = 0; i < 14; i++) begin
         q.delete();
         q.push_back(vt[i].x);
         e0 = en_cycles;
         apply(q);
         chk($sformatf("vec%0d_hresp", i), 32'(res_q[0].resp), 32'(vt[i].resp));
         chk($sformatf("vec%0d_waits", i), 32'(res_q[0].waits), 32'(vt[i].waits));
         chk($sformatf("vec%0d_stall_hresp", i), 32'(res_q[0].stall_resp), 32'(vt[i].resp));
         chk($sformatf("vec%0d_hrdata", i), res_q[0].rdata, vt[i].rdata);
         chk($sformatf("vec%0d_sp_en_cycles", i), 32'(en_cycles - e0), 32'(vt[i].en));
         chk($sformatf("vec%0d_err_count", i), 32'(err_count), 32'(vt[i].err));
         chk($sformatf("vec%0d_fields", i), 32'(fld_now()), 32'(vt[i].fld));
      end

      // Reset while the read is in its wait state
      HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0; HSIZE = HSIZE_WORD; HADDR = 32'h10D4;
      @(posedge HCLK);
      #1;
      drive_idle();
      chk("rst_mid_rd_stalled", 32'(HREADYOUT), 32'h0);
      chk("rst_mid_rd_sp_en", 32'(sp_en), 32'h1);
      HRESETn = 1'b0;
      #1;
      chk("rst_mid_rd_hreadyout", 32'(HREADYOUT), 32'h1);
      chk("rst_mid_rd_sp_en_off", 32'(sp_en), 32'h0);
      chk("rst_mid_rd_hresp", 32'(HRESP), 32'h0);
      chk("rst_mid_rd_err_count", 32'(err_count), 32'h0);
      chk("rst_mid_rd_fields", 32'(fld_now()), 32'h0);
      ref_err = 0;
      @(negedge HCLK);
      HRESETn = 1'b1;
      @(posedge HCLK);
      #1;

      // Two illegal accesses back to back
      q.delete();
      q.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h0040, 32'h0));
      q.push_back(mk(1, HTRANS_NONSEQ, 1, 3'b000, 32'h0000, 32'h5));
      e0 = en_cycles;
      apply(q);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("errpair%0d_hresp", k), 32'(res_q[k].resp), 32'h1);
         chk($sformatf("errpair%0d_waits", k), 32'(res_q[k].waits), 32'h1);
         chk($sformatf("errpair%0d_stall_hresp", k), 32'(res_q[k].stall_resp), 32'h1);
      end
      chk("errpair_sp_en_cycles", 32'(en_cycles - e0), 32'h0);
      chk("errpair_err_count", 32'(err_count), 32'h2);

      // Write then read of the same word without a gap
      q.delete();
      q.push_back(mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h0004, 32'hCAFE0004));
      q.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h0004, 32'h0));
      apply(q);
      total = 2 + res_q[0].waits + res_q[1].waits;
      chk("b2b_cycles", 32'(total), 32'd3);
      chk("b2b_readback", res_q[1].rdata, 32'hCAFE0004);
      chk("b2b_hresp", 32'(res_q[1].resp), 32'h0);

      q.delete();
      q.push_back(mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h1008, 32'h0BADF00D));
      q.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h1008, 32'h0));
      q.push_back(mk(1, HTRANS_SEQ,    1, HSIZE_WORD, 32'h1008, 32'h600DCAFE));
      q.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h1008, 32'h0));
      q.push_back(mk(1, HTRANS_SEQ,    0, HSIZE_WORD, 32'h10D4, 32'h0));
      apply(q);
      total = 0;
      foreach (res_q[k]) total += 1 + res_q[k].waits;
      chk("burst_cycles", 32'(total), 32'd8);
      chk("burst_rd1", res_q[1].rdata, 32'h0BADF00D);
      chk("burst_rd3", res_q[3].rdata, 32'h600DCAFE);
      chk("burst_rd4", res_q[4].rdata, 32'hDEADBEEF);

      // Random traffic against the model
      e0 = en_cycles;
      r0 = ref_en;
      for (int b = 0; b < 5; b++) begin
         q.delete();
         for (int k = 0; k < 60; k++) q.push_back(rnd_xfer());
         apply(q);
         for (int k = 0; k < 60; k++) begin
            chk($sformatf("rnd%0d_%0d_hresp", b, k), 32'(res_q[k].resp), 32'(exp_q[k].resp));
            chk($sformatf("rnd%0d_%0d_waits", b, k), 32'(res_q[k].waits), 32'(exp_q[k].waits));
            chk($sformatf("rnd%0d_%0d_stall_hresp", b, k), 32'(res_q[k].stall_resp), 32'(exp_q[k].stall_resp));
            chk($sformatf("rnd%0d_%0d_hrdata", b, k), res_q[k].rdata, exp_q[k].rdata);
         end
         chk($sformatf("rnd%0d_err_count", b), 32'(err_count), 32'(ref_err));
      end
      chk("rnd_sp_en_cycles", 32'(en_cycles - e0), 32'(ref_en - r0));

      // Saturation of the error counter
      q.delete();
      for (int k = 0; k < 300; k++) begin
         if (k % 2 == 0) q.push_back(mk(1, HTRANS_NONSEQ, 1'(k % 4 == 0), HSIZE_WORD, 32'h0040, 32'h0));
         else q.push_back(mk(1, HTRANS_SEQ, 1'b0, 3'b001, 32'h10D4, 32'h0));
      end
      apply(q);
      chk("sat_err_count", 32'(err_count), 32'd255);
      chk("sat_err_model", 32'(err_count), 32'(ref_err));

      q.delete();
      q.push_back(mk(1, HTRANS_BUSY, 0, HSIZE_WORD, 32'h10D4, 32'h0));
      e0 = en_cycles;
      apply(q);
      chk("busy_hresp", 32'(res_q[0].resp), 32'h0);
      chk("busy_waits", 32'(res_q[0].waits), 32'h0);
      chk("busy_sp_en_cycles", 32'(en_cycles - e0), 32'h0);
      chk("busy_err_count", 32'(err_count), 32'd255);

      chk("data_in_outside_write", 32'(dat_leak), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
